// File: rtl/sym_pkg.sv
// Shared types and helpers for the symbol-matching game.
// SYM_MATCH_SPECIAL_EN adds a special (double-weight) flag to each queue entry.
package sym_pkg;
  localparam int SYM_W = 8;

  typedef enum logic [1:0] {IDLE, PLAY, DONE} state_e;

`ifdef SYM_MATCH_SPECIAL_EN
  typedef struct packed {
    logic             special;
    logic [SYM_W-1:0] sym;
  } entry_t;
`else
  typedef struct packed {
    logic [SYM_W-1:0] sym;
  } entry_t;
`endif

  // misses counter is 8 bits and clamps at 255
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [4:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {4'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction
endpackage

// File: rtl/sym_match_if.sv
// Game-side bus of sym_match: generator/keypad strobes in, score and status out.
interface sym_match_if #(
  parameter int DEPTH   = 8,
  parameter int SCORE_W = 16
);
  import sym_pkg::*;

  logic                    genSym;
  logic                    generated;
  logic                    special;
  logic [SYM_W-1:0]        generatedSym;
  logic                    keyValid;
  logic [SYM_W-1:0]        keySym;
  logic [SCORE_W-1:0]      score;
  logic [7:0]              misses;
  logic                    match;
  logic                    mismatch;
  logic [SYM_W-1:0]        curSym;
  logic [$clog2(DEPTH):0]  pending;
  logic                    overflow;
  logic                    gameOver;

  modport slave (
    input  genSym, generated, special, generatedSym, keyValid, keySym,
    output score, misses, match, mismatch, curSym, pending, overflow, gameOver
  );
  modport master (
    output genSym, generated, special, generatedSym, keyValid, keySym,
    input  score, misses, match, mismatch, curSym, pending, overflow, gameOver
  );
endinterface

// File: rtl/sym_fifo.sv
// Show-ahead synchronous FIFO of pending symbols; push on full is accepted only with a pop.
module sym_fifo
  import sym_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   push,
  input  logic                   pop,
  input  entry_t                 din,
  output entry_t                 dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem_q[rd_q];
  assign count   = cnt_q;

  // pointers are AW bits wide so they wrap modulo DEPTH on their own
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (clr) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem_q[wr_q] <= din;
  end
endmodule

// File: rtl/sym_match.sv
// Symbol-matching game: FSM, scoring and miss accounting around a sym_fifo queue.
// Optional SYM_MATCH_SPECIAL_EN: special entries weigh 2 on match and on mismatch.
module sym_match
  import sym_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int SCORE_W = 16
) (
  input  logic      Clk100M,
  input  logic      Reset,
  sym_match_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [7:0]         misses_q, misses_d;
  logic               match_q, match_d, mismatch_q, mismatch_d;
  logic               overflow_q, overflow_d;

  logic               f_push, f_pop, f_clr, f_full, f_empty;
  entry_t             f_din, f_head;
  logic [CW-1:0]      f_count;
  logic [1:0]         weight;
  logic [4:0]         miss_inc;
  logic [SCORE_W:0]   score_sum;

  sym_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(Clk100M), .rst(Reset), .clr(f_clr), .push(f_push), .pop(f_pop),
    .din(f_din), .dout(f_head), .full(f_full), .empty(f_empty), .count(f_count)
  );

`ifdef SYM_MATCH_SPECIAL_EN
  always_comb begin
    f_din.special = bus.special;
    f_din.sym     = bus.generatedSym;
    weight        = f_head.special ? 2'd2 : 2'd1;
  end
`else
  logic unused_special;
  assign unused_special = bus.special;
  always_comb begin
    f_din.sym = bus.generatedSym;
    weight    = 2'd1;
  end
`endif

  always_comb begin
    state_d    = state_q;
    score_d    = score_q;
    misses_d   = misses_q;
    overflow_d = overflow_q;
    match_d    = 1'b0;
    mismatch_d = 1'b0;
    f_push     = 1'b0;
    f_pop      = 1'b0;
    f_clr      = 1'b0;
    miss_inc   = '0;
    score_sum  = {1'b0, score_q} + (SCORE_W+1)'(weight);
    case (state_q)
      PLAY: begin
        // strobes arriving with genSym already low belong to the finished game
        if (!bus.genSym) begin
          state_d  = DONE;
          f_clr    = 1'b1;
          misses_d = sat_add8(misses_q, 5'(f_count));
        end else begin
          if (bus.keyValid) begin
            if (f_empty) begin
              mismatch_d = 1'b1;
              miss_inc   = 5'd1;
            end else begin
              f_pop = 1'b1;
              if (bus.keySym == f_head.sym) begin
                match_d = 1'b1;
                score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
              end else begin
                mismatch_d = 1'b1;
                miss_inc   = 5'(weight);
              end
            end
          end
          if (bus.generated) begin
            if (f_full && !f_pop) begin
              overflow_d = 1'b1;
              miss_inc   = miss_inc + 5'd1;
            end else begin
              f_push = 1'b1;
            end
          end
          misses_d = sat_add8(misses_q, miss_inc);
        end
      end
      default: begin
        if (bus.genSym) begin
          state_d    = PLAY;
          score_d    = '0;
          misses_d   = '0;
          overflow_d = 1'b0;
          f_clr      = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge Clk100M) begin
    if (Reset) begin
      state_q    <= IDLE;
      score_q    <= '0;
      misses_q   <= '0;
      match_q    <= 1'b0;
      mismatch_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      score_q    <= score_d;
      misses_q   <= misses_d;
      match_q    <= match_d;
      mismatch_q <= mismatch_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.score    = score_q;
  assign bus.misses   = misses_q;
  assign bus.match    = match_q;
  assign bus.mismatch = mismatch_q;
  assign bus.curSym   = f_head.sym;
  assign bus.pending  = f_count;
  assign bus.overflow = overflow_q;
  assign bus.gameOver = (state_q == DONE);
endmodule

// File: tb/tb_sym_match.sv
// Directed bench for sym_match with a reference queue model and a pulse scoreboard.
module tb_sym_match;
  localparam int DEPTH   = 8;
  localparam int SCORE_W = 16;
`ifdef SYM_MATCH_SPECIAL_EN
  localparam int SPECIAL_SCORE = 2;
`else
  localparam int SPECIAL_SCORE = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sym_match_if #(.DEPTH(DEPTH), .SCORE_W(SCORE_W)) bus ();
  sym_match #(.DEPTH(DEPTH), .SCORE_W(SCORE_W)) dut (
    .Clk100M(clk), .Reset(rst), .bus(bus)
  );

  int         nchk  = 0;
  int         nfail = 0;
  logic [8:0] mq[$];
  logic [1:0] sb[$];
  int         m_score, m_misses;
  bit         m_ovf, m_play, m_done;

  function automatic int w_of(input logic [8:0] e);
`ifdef SYM_MATCH_SPECIAL_EN
    return e[8] ? 2 : 1;
`else
    return (e[8] === 1'bx) ? 0 : 1;
`endif
  endfunction

  function automatic int sat_m(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all(input string tag);
    logic [1:0]  ep;
    logic [8:0]  h;
    logic [31:0] cur;
    ep  = sb.pop_front();
    cur = 0;
    if (mq.size() > 0) begin
      h   = mq[0];
      cur = {24'b0, h[7:0]};
    end
    chk({tag, ".pulse"},    {30'b0, bus.match, bus.mismatch}, {30'b0, ep});
    chk({tag, ".score"},    {16'b0, bus.score}, m_score);
    chk({tag, ".misses"},   {24'b0, bus.misses}, m_misses);
    chk({tag, ".pending"},  {28'b0, bus.pending}, mq.size());
    chk({tag, ".curSym"},   {24'b0, bus.curSym}, cur);
    chk({tag, ".overflow"}, {31'b0, bus.overflow}, {31'b0, m_ovf});
    chk({tag, ".gameOver"}, {31'b0, bus.gameOver}, {31'b0, m_done});
  endtask

  task automatic step(input string tag, input bit g, input logic [7:0] gs, input bit sp,
                      input bit k, input logic [7:0] ks);
    logic [1:0] ep;
    logic [8:0] e;
    bus.generated = g; bus.generatedSym = gs; bus.special = sp;
    bus.keyValid  = k; bus.keySym = ks;
    ep = 2'b00;
    if (m_play) begin
      if (k) begin
        if (mq.size() == 0) begin
          ep = 2'b01; m_misses = sat_m(m_misses + 1);
        end else begin
          e = mq.pop_front();
          if (e[7:0] == ks) begin
            ep = 2'b10;
            m_score = (m_score + w_of(e) > 65535) ? 65535 : m_score + w_of(e);
          end else begin
            ep = 2'b01; m_misses = sat_m(m_misses + w_of(e));
          end
        end
      end
      if (g) begin
        if (mq.size() == DEPTH) begin
          m_ovf = 1'b1; m_misses = sat_m(m_misses + 1);
        end else mq.push_back({sp, gs});
      end
    end
    sb.push_back(ep);
    tick();
    bus.generated = 1'b0; bus.keyValid = 1'b0;
    check_all(tag);
  endtask

  task automatic set_gen(input string tag, input bit v);
    bus.genSym = v;
    if (v && !m_play) begin
      m_play = 1; m_done = 0; m_score = 0; m_misses = 0; m_ovf = 0; mq.delete();
    end else if (!v && m_play) begin
      m_play = 0; m_done = 1; m_misses = sat_m(m_misses + mq.size()); mq.delete();
    end
    sb.push_back(2'b00);
    tick();
    check_all(tag);
  endtask

  task automatic model_reset();
    m_play = 0; m_done = 0; m_score = 0; m_misses = 0; m_ovf = 0;
    mq.delete(); sb.delete();
  endtask

  initial begin
    logic [8:0] h;
    rst = 1'b1;
    bus.genSym = 0; bus.generated = 0; bus.special = 0; bus.generatedSym = 0;
    bus.keyValid = 0; bus.keySym = 0;
    model_reset();
    tick(); tick();
    sb.push_back(2'b00);
    check_all("reset");
    rst = 1'b0;

    // basic match
    set_gen("start", 1);
    step("push41", 1, 8'h41, 0, 0, 8'h00);
    step("key41", 0, 8'h00, 0, 1, 8'h41);
    chk("req037.score", {16'b0, bus.score}, 32'd1);
    step("idle_after_match", 0, 8'h00, 0, 0, 8'h00);

    // mismatch, key on empty queue, push+key on empty
    step("push41b", 1, 8'h41, 0, 0, 8'h00);
    step("key42", 0, 8'h00, 0, 1, 8'h42);
    step("key_empty", 0, 8'h00, 0, 1, 8'h42);
    chk("req038.misses", {24'b0, bus.misses}, 32'd2);
    step("push_key_empty", 1, 8'h55, 0, 1, 8'h55);
    step("key55", 0, 8'h00, 0, 1, 8'h55);

    // overflow and full-queue push+pop, then drain across the wrap
    set_gen("end1", 0);
    set_gen("start2", 1);
    for (int i = 0; i < 9; i++) step("fill", 1, 8'(8'h10 + i), 0, 0, 8'h00);
    chk("req039.misses", {24'b0, bus.misses}, 32'd1);
    chk("req039.overflow", {31'b0, bus.overflow}, 32'd1);
    step("full_push_pop", 1, 8'h20, 0, 1, 8'h10);
    chk("req039.pending", {28'b0, bus.pending}, 32'd8);
    for (int i = 0; i < 8; i++) begin
      h = mq[0];
      step("drain", 0, 8'h00, 0, 1, h[7:0]);
    end
    step("drain_empty", 0, 8'h00, 0, 0, 8'h00);

    // game end accounting; strobes ignored while DONE
    set_gen("end2", 0);
    set_gen("start3", 1);
    for (int i = 0; i < 3; i++) step("push3", 1, 8'(8'h60 + i), 0, 0, 8'h00);
    set_gen("end3", 0);
    chk("req040.misses", {24'b0, bus.misses}, 32'd3);
    step("done_ignore", 1, 8'h77, 0, 1, 8'h77);
    set_gen("start4", 1);

    // special-weighted entries
    step("push_sp", 1, 8'h30, 1, 0, 8'h00);
    step("key_sp", 0, 8'h00, 0, 1, 8'h30);
    chk("req041.score", {16'b0, bus.score}, SPECIAL_SCORE);
    step("push_sp2", 1, 8'h31, 1, 0, 8'h00);
    step("key_sp_wrong", 0, 8'h00, 0, 1, 8'h32);

    // misses clamps at 255
    set_gen("end5", 0);
    set_gen("start6", 1);
    for (int i = 0; i < 258; i++) step("miss_sat", 0, 8'h00, 0, 1, 8'h00);
    chk("req028.misses", {24'b0, bus.misses}, 32'd255);

    // reset mid-game together with a key
    set_gen("end7", 0);
    set_gen("start8", 1);
    for (int i = 0; i < 5; i++) step("push5", 1, 8'(8'ha0 + i), 0, 0, 8'h00);
    step("key_a0", 0, 8'h00, 0, 1, 8'ha0);
    bus.keyValid = 1'b1; bus.keySym = 8'ha1; bus.genSym = 1'b0;
    rst = 1'b1;
    tick();
    bus.keyValid = 1'b0;
    model_reset();
    sb.push_back(2'b00);
    check_all("rst_mid");
    rst = 1'b0;
    step("after_rst", 0, 8'h00, 0, 0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/sym_match.md
SYM_MATCH -- requirements
Module: sym_match

Interface
REQ-001 Parameter DEPTH, default 8, pending-symbol queue depth (power of 2, 2..16).
REQ-002 Parameter SCORE_W, default 16, score counter width.
REQ-003 Clk100M  input  1  system clock; all logic on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 genSym  input  1  game period active (level).
REQ-006 generated  input  1  one-cycle strobe: new symbol from generator.
REQ-007 special  input  1  qualifies generatedSym as special; sampled with generated.
REQ-008 generatedSym  input  8  symbol code; sampled with generated.
REQ-009 keyValid  input  1  one-cycle strobe: player entered a symbol.
REQ-010 keySym  input  8  player symbol; sampled with keyValid.
REQ-011 score  output  SCORE_W  accumulated points.
REQ-012 misses  output  8  wrong, late or dropped symbols.
REQ-013 match  output  1  one-cycle pulse: key equals queue head.
REQ-014 mismatch  output  1  one-cycle pulse: key wrong or queue empty.
REQ-015 curSym  output  8  queue head symbol; 0 when empty.
REQ-016 pending  output  $clog2(DEPTH)+1  queue occupancy.
REQ-017 overflow  output  1  sticky: symbol dropped on full queue.
REQ-018 gameOver  output  1  high in DONE state.

Function
REQ-019 FSM states IDLE, PLAY, DONE; IDLE->PLAY on genSym=1; PLAY->DONE on genSym=0; DONE->PLAY on genSym=1.
REQ-020 Every entry into PLAY clears score, misses, overflow and the queue in that cycle; strobes in that cycle are ignored.
REQ-021 In PLAY, generated=1 pushes {special, generatedSym}; visible in pending/curSym next cycle.
REQ-022 In PLAY, keyValid=1 with queue non-empty compares keySym to head, pops head; equal -> match pulse, score+1; unequal -> mismatch pulse, misses+1.
REQ-023 match/mismatch pulse exactly one cycle, asserted the cycle after keyValid.
REQ-024 keyValid with queue empty -> mismatch pulse, misses+1, no pop.
REQ-025 Simultaneous push and pop with queue full: pop occurs, push accepted, no overflow.
REQ-026 Push with queue full and no pop: symbol dropped, overflow set, misses+1.
REQ-027 Push and key on empty queue same cycle: key judged against empty (REQ-024); pushed symbol retained.
REQ-028 score saturates at all-ones; misses saturates at 255.
REQ-029 PLAY->DONE transition adds pending to misses (saturating) and empties queue in one cycle.
REQ-030 In IDLE and DONE, generated and keyValid are ignored; score/misses hold.
REQ-031 Queue pointers wrap modulo DEPTH.

Reset
REQ-032 Reset=1: state IDLE, queue empty, score=0, misses=0, match=0, mismatch=0, curSym=0, pending=0, overflow=0, gameOver=0.
REQ-033 Reset overrides all inputs, including mid-game; a pulse pending from the prior cycle is suppressed.

Configuration
REQ-034 Macro SYM_MATCH_SPECIAL_EN: when defined, a match on a special entry adds 2 to score and a mismatch on a special entry adds 2 to misses; when undefined, special is ignored, not stored, all entries weigh 1.

Structure
REQ-035 Package sym_pkg holds SYM_W=8, the state enum (IDLE, PLAY, DONE) and the queue entry typedef.
REQ-036 Queue is sub-module sym_fifo (synchronous, show-ahead, push/pop/full/empty/count); FSM and scoring in sym_match.

Verification
REQ-037 Reset, genSym=1, push 0x41, key 0x41 -> match pulse 1 cycle later, score=1, pending=0.
REQ-038 Push 0x41, key 0x42 -> mismatch pulse, misses=1, pending=0; key with empty queue -> mismatch, misses=2.
REQ-039 DEPTH=8: 9 pushes without keys -> pending=8, overflow=1, misses=1; push+key same cycle at full -> pending stays 8, overflow unchanged.
REQ-040 3 pushes then genSym=0 -> gameOver=1, misses=3, pending=0; genSym=1 -> score=0, misses=0.
REQ-041 With SYM_MATCH_SPECIAL_EN: push 0x30 special=1, key 0x30 -> score=2; without macro -> score=1.
REQ-042 Reset asserted in PLAY with pending=4 the cycle after a key -> all outputs per REQ-032, no match/mismatch pulse.
